// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Imported by fetch and decode stages.
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_JAL    = 2'b11
  } next_pc_sel_t;

  typedef enum logic [1:0] {
    S_REQ   = 2'b00,
    S_WAIT  = 2'b01,
    S_HOLD  = 2'b10,
    S_FAULT = 2'b11
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Next-PC target selection for the fetch unit.
// Purely combinational; flags misaligned targets.
import riscv_pkg::*;

module next_pc_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  next_pc_sel_t    sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;

  assign seq_pc = pc + XLEN'(INSTR_BYTES);
  assign rel_pc = pc + immediate;

  // select the target; JALR always drops bit 0
  always_comb begin
    next_pc = seq_pc;
    unique case (sel)
      PC_SEQ:    next_pc = seq_pc;
      PC_BRANCH: next_pc = branch_taken ? rel_pc : seq_pc;
      PC_JALR:   next_pc = {alu_result[XLEN-1:1], 1'b0};
      PC_JAL:    next_pc = rel_pc;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: PC, one-outstanding imem fetch,
// instruction hold for decode and retire count.
import riscv_pkg::*;

module instruction_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instruction_pc,
  output logic            instruction_valid,
  input  logic            instruction_ready,
  input  logic [1:0]      next_pc_selector,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] alu_result,
  output logic            fetch_misaligned,
  output logic [63:0]     instret
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;
  logic            next_bad;
  logic            retire;
  logic            rsp_take;

  next_pc_calc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .pc          (instruction_pc),
    .sel         (next_pc_sel_t'(next_pc_selector)),
    .branch_taken(branch_taken),
    .immediate   (immediate),
    .alu_result  (alu_result),
    .next_pc     (next_pc),
    .misaligned  (next_bad)
  );

  assign retire   = (state_q == S_HOLD) && instruction_ready;
  assign rsp_take = (state_q == S_WAIT) && imem_rsp_valid;

  assign imem_req_valid    = (state_q == S_REQ);
  assign instruction_valid = (state_q == S_HOLD);
  assign imem_req_addr     = pc_q;

  // fetch state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // fetch sequencing: request, wait, hold, fault
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:   if (imem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_d = S_HOLD;
      S_HOLD:  if (instruction_ready)
                 state_d = next_bad ? S_FAULT : S_REQ;
      S_FAULT: state_d = S_FAULT;
    endcase
  end

  // PC, held instruction, retire counter, fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      instruction      <= '0;
      instruction_pc   <= '0;
      instret          <= '0;
      fetch_misaligned <= 1'b0;
    end else begin
      if (rsp_take) begin
        instruction    <= imem_rsp_data;
        instruction_pc <= pc_q;
      end
      if (retire) begin
        pc_q    <= next_pc;
        instret <= instret + 64'd1;
        if (next_bad) fetch_misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for the fetch unit.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [1:0]  next_pc_selector;
  logic        branch_taken;
  logic [31:0] immediate;
  logic [31:0] alu_result;
  logic        fetch_misaligned;
  logic [63:0] instret;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_instret = 64'd0;

  instruction_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .instruction      (instruction),
    .instruction_pc   (instruction_pc),
    .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready),
    .next_pc_selector (next_pc_selector),
    .branch_taken     (branch_taken),
    .immediate        (immediate),
    .alu_result       (alu_result),
    .fetch_misaligned (fetch_misaligned),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_instret = 64'd0;
  endtask

  task automatic do_fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic do_retire(input logic [1:0] sel, input logic tk,
                           input logic [31:0] imm, input logic [31:0] alu);
    next_pc_selector  = sel;
    branch_taken      = tk;
    immediate         = imm;
    alu_result        = alu;
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    exp_instret       = exp_instret + 64'd1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (imem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_valid got=%b exp=1", imem_req_valid);
    end
    checks++;
    if (imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=00000000", imem_req_addr);
    end
    checks++;
    if (instruction_valid !== 1'b0 || instruction !== 32'h0 ||
        instruction_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_instr got v=%b i=%h pc=%h exp 0/0/0",
               instruction_valid, instruction, instruction_pc);
    end
    checks++;
    if (instret !== 64'd0 || fetch_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_counters got instret=%0d mis=%b exp 0/0",
               instret, fetch_misaligned);
    end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] d;
      logic [31:0] a;
      d = 32'hA000_0013 + (i << 8);
      a = 32'(i * 4);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
        failures++;
        $display("FAIL seq_req got v=%b a=%h exp v=1 a=%h",
                 imem_req_valid, imem_req_addr, a);
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      checks++;
      if (instruction_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_wait got iv=%b rv=%b exp 0/0",
                 instruction_valid, imem_req_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = d;
      tick();
      imem_rsp_valid = 1'b0;
      checks++;
      if (instruction_valid !== 1'b1 || instruction !== d ||
          instruction_pc !== a) begin
        failures++;
        $display("FAIL seq_hold got v=%b i=%h pc=%h exp 1 %h %h",
                 instruction_valid, instruction, instruction_pc, d, a);
      end
      do_retire(2'b00, 1'b0, 32'h0, 32'h0);
      checks++;
      if (imem_req_valid !== 1'b1) begin
        failures++;
        $display("FAIL seq_next_req got=%b exp=1", imem_req_valid);
      end
    end
    checks++;
    if (imem_req_addr !== 32'h0000_000C || instret !== 64'd3) begin
      failures++;
      $display("FAIL seq_after3 got a=%h n=%0d exp a=0000000c n=3",
               imem_req_addr, instret);
    end
  endtask

  task automatic test_branch;
    do_fetch(32'h0000_0013);
    do_retire(2'b00, 1'b0, 32'h0, 32'h0);
    do_fetch(32'hFE00_0CE3);
    checks++;
    if (instruction_pc !== 32'h0000_0010) begin
      failures++;
      $display("FAIL br_pc got=%h exp=00000010", instruction_pc);
    end
    do_retire(2'b01, 1'b1, 32'hFFFF_FFF8, 32'h0);
    checks++;
    if (imem_req_addr !== 32'h0000_0008) begin
      failures++;
      $display("FAIL br_taken got=%h exp=00000008", imem_req_addr);
    end
    do_fetch(32'h0080_006F);
    do_retire(2'b11, 1'b0, 32'h0000_0008, 32'h0);
    checks++;
    if (imem_req_addr !== 32'h0000_0010) begin
      failures++;
      $display("FAIL jal_fwd got=%h exp=00000010", imem_req_addr);
    end
    do_fetch(32'hFE00_0CE3);
    do_retire(2'b01, 1'b0, 32'hFFFF_FFF8, 32'h0);
    checks++;
    if (imem_req_addr !== 32'h0000_0014 || instret !== exp_instret) begin
      failures++;
      $display("FAIL br_not_taken got a=%h n=%0d exp a=00000014 n=%0d",
               imem_req_addr, instret, exp_instret);
    end
  endtask

  task automatic test_jalr;
    do_fetch(32'h0000_8067);
    do_retire(2'b10, 1'b0, 32'h0, 32'h0000_0101);
    checks++;
    if (imem_req_addr !== 32'h0000_0100 || fetch_misaligned !== 1'b0 ||
        imem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL jalr got a=%h mis=%b v=%b exp 00000100 0 1",
               imem_req_addr, fetch_misaligned, imem_req_valid);
    end
  endtask

  task automatic test_jal_fault;
    int bad;
    do_fetch(32'h0000_8067);
    do_retire(2'b10, 1'b0, 32'h0, 32'h0000_0020);
    checks++;
    if (imem_req_addr !== 32'h0000_0020) begin
      failures++;
      $display("FAIL jalr_to20 got=%h exp=00000020", imem_req_addr);
    end
    do_fetch(32'h0060_006F);
    do_retire(2'b11, 1'b0, 32'h0000_0006, 32'h0);
    checks++;
    if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0 ||
        instruction_valid !== 1'b0 || imem_req_addr !== 32'h0000_0026) begin
      failures++;
      $display("FAIL fault_entry got mis=%b rv=%b iv=%b a=%h exp 1 0 0 00000026",
               fetch_misaligned, imem_req_valid, instruction_valid,
               imem_req_addr);
    end
    bad = 0;
    imem_req_ready    = 1'b1;
    imem_rsp_valid    = 1'b1;
    imem_rsp_data     = 32'hDEAD_BEEF;
    instruction_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req_valid !== 1'b0 || fetch_misaligned !== 1'b1 ||
          imem_req_addr !== 32'h0000_0026) bad++;
    end
    imem_req_ready    = 1'b0;
    imem_rsp_valid    = 1'b0;
    instruction_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fault_hold got bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (instret !== exp_instret || instruction === 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL fault_quiet got n=%0d i=%h exp n=%0d i!=deadbeef",
               instret, instruction, exp_instret);
    end
    do_reset();
    checks++;
    if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 ||
        imem_req_addr !== 32'h0 || instret !== 64'd0) begin
      failures++;
      $display("FAIL fault_clear got mis=%b v=%b a=%h n=%0d exp 0 1 0 0",
               fetch_misaligned, imem_req_valid, imem_req_addr, instret);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_req_stable got bad_cycles=%0d exp=0", bad);
    end
    do_fetch(32'h1234_5678);
    bad = 0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instruction !== 32'h1234_5678 || instruction_valid !== 1'b1 ||
          instret !== 64'd0 || instruction_pc !== 32'h0) bad++;
    end
    imem_rsp_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold_stable got bad_cycles=%0d exp=0", bad);
    end
    do_retire(2'b00, 1'b0, 32'h0, 32'h0);
    checks++;
    if (instret !== 64'd1 || imem_req_addr !== 32'h4) begin
      failures++;
      $display("FAIL bp_retire got n=%0d a=%h exp n=1 a=00000004",
               instret, imem_req_addr);
    end
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    checks++;
    if (instret !== 64'd1 || imem_req_addr !== 32'h4 ||
        imem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_in_req got n=%0d a=%h v=%b exp 1 00000004 1",
               instret, imem_req_addr, imem_req_valid);
    end
  endtask

  task automatic test_reset_in_wait;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0 || instruction_valid !== 1'b0) begin
      failures++;
      $display("FAIL rw_in_wait got rv=%b iv=%b exp 0 0",
               imem_req_valid, instruction_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (instruction_valid !== 1'b0 || instruction !== 32'h0 ||
        imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL rw_discard got iv=%b i=%h rv=%b a=%h exp 0 0 1 0",
               instruction_valid, instruction, imem_req_valid, imem_req_addr);
    end
    do_fetch(32'h0051_0093);
    checks++;
    if (instruction !== 32'h0051_0093 || instruction_pc !== 32'h0 ||
        instruction_valid !== 1'b1) begin
      failures++;
      $display("FAIL rw_refetch got i=%h pc=%h v=%b exp 00510093 0 1",
               instruction, instruction_pc, instruction_valid);
    end
  endtask

  initial begin
    rst               = 1'b1;
    imem_req_ready    = 1'b0;
    imem_rsp_valid    = 1'b0;
    imem_rsp_data     = 32'h0;
    instruction_ready = 1'b0;
    next_pc_selector  = 2'b00;
    branch_taken      = 1'b0;
    immediate         = 32'h0;
    alu_result        = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_jal_fault();
    test_backpressure();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
